// File: rtl/mips_pkg.sv
// Shared fetch-side types and constants for the multi-cycle MIPS core.
// Holds the fetch FSM encoding, the sequential PC step and the redirect alignment helper.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Wide enough for IMEM_LATENCY-1 over the legal latency range 1..7.
  localparam int LAT_W = 3;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_lat_counter.sv
// Latency down-counter for the fetch WAIT phase; zero is combinational from the count register.
// Load has priority over decrement; decrement saturates at zero; no backpressure.
module fetch_lat_counter
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - LAT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and fetch sequencer: fetch_en -> fetch_done in IMEM_LATENCY+2 cycles, redirects via pc_load.
// No queuing: fetch_en while busy is dropped; redirects while busy are parked and applied at capture.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        pc_load,
  input  logic [31:0] pc_in,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        fetch_done,
  output logic        busy,
  output logic        pc_misalign
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(IMEM_LATENCY - 1);

  fetch_state_t state;
  logic         pend_vld;
  logic [31:0]  pend_tgt;
  logic         start_pend;
  logic         cnt_zero;

  logic [31:0]  ld_tgt;
  logic [31:0]  pc_seq;

  assign ld_tgt = align_pc(pc_in);
  assign pc_seq = pc + PC_STEP;
  assign busy   = (state != ST_IDLE);

  fetch_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_REQ),
    .load_val (LAT_LOAD),
    .dec      (state == ST_WAIT),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      pc_plus4    <= '0;
      imem_addr   <= '0;
      imem_rd_en  <= 1'b0;
      fetch_done  <= 1'b0;
      pc_misalign <= 1'b0;
      pend_vld    <= 1'b0;
      pend_tgt    <= '0;
      start_pend  <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      if (pc_load && (pc_in[1:0] != 2'b00)) begin
        pc_misalign <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          // A redirect wins the cycle; a coincident start is deferred so the
          // request goes out at the new PC, never the stale one.
          if (pc_load) begin
            pc         <= ld_tgt;
            start_pend <= start_pend | fetch_en;
          end else if (fetch_en || start_pend) begin
            start_pend <= 1'b0;
            imem_addr  <= pc;
            imem_rd_en <= 1'b1;
            state      <= ST_REQ;
          end
        end

        ST_REQ: begin
          imem_rd_en <= 1'b0;
          state      <= ST_WAIT;
          if (pc_load) begin
            pend_vld <= 1'b1;
            pend_tgt <= ld_tgt;
          end
        end

        ST_WAIT: begin
          if (cnt_zero) begin
            instr      <= imem_rdata;
            pc_plus4   <= pc_seq;
            fetch_done <= 1'b1;
            pend_vld   <= 1'b0;
            state      <= ST_CAPT;
            if (pc_load) begin
              pc <= ld_tgt;
            end else if (pend_vld) begin
              pc <= pend_tgt;
            end else begin
              pc <= pc_seq;
            end
          end else if (pc_load) begin
            pend_vld <= 1'b1;
            pend_tgt <= ld_tgt;
          end
        end

        ST_CAPT: begin
          // Last busy cycle: nothing left to defer to, so a redirect lands directly.
          state <= ST_IDLE;
          if (pc_load) begin
            pc <= ld_tgt;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: default-latency instance for the main flow, latency-4 instance for abort.
// Stimulus pushes expected fetch addresses and capture results; monitor pops on imem_rd_en / fetch_done.
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pp4;
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // default-latency instance
  logic        rst = 1'b1, fetch_en = 1'b0, pc_load = 1'b0;
  logic [31:0] pc_in = '0, imem_rdata, imem_addr, pc, pc_plus4, instr;
  logic        imem_rd_en, fetch_done, busy, pc_misalign;

  // latency-4 instance
  logic        rst4 = 1'b1, fetch_en4 = 1'b0, pc_load4 = 1'b0;
  logic [31:0] pc_in4 = '0, imem_rdata4, imem_addr4, pc4, pc_plus44, instr4;
  logic        imem_rd_en4, fetch_done4, busy4, pc_misalign4;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  exp_t        mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_load(pc_load), .pc_in(pc_in),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .fetch_done(fetch_done),
    .busy(busy), .pc_misalign(pc_misalign)
  );

  pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst4), .fetch_en(fetch_en4), .pc_load(pc_load4), .pc_in(pc_in4),
    .imem_rdata(imem_rdata4), .imem_addr(imem_addr4), .imem_rd_en(imem_rd_en4),
    .pc(pc4), .pc_plus4(pc_plus44), .instr(instr4), .fetch_done(fetch_done4),
    .busy(busy4), .pc_misalign(pc_misalign4)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2002_0005 : (32'h8C00_0000 ^ a);
  endfunction

  // Memory models: data valid exactly IMEM_LATENCY cycles after the read strobe, junk otherwise.
  logic        m1_vld = 1'b0;
  logic [31:0] m1_addr = '0;
  logic [3:0]  m4_vld = '0;
  logic [31:0] m4_addr [4];

  always @(posedge clk) begin
    m1_vld  <= imem_rd_en;
    m1_addr <= imem_addr;
    m4_vld  <= {m4_vld[2:0], imem_rd_en4};
    m4_addr[0] <= imem_addr4;
    for (int i = 1; i < 4; i++) m4_addr[i] <= m4_addr[i-1];
  end

  assign imem_rdata  = m1_vld    ? mem_word(m1_addr)    : 32'hDEAD_BEEF;
  assign imem_rdata4 = m4_vld[3] ? mem_word(m4_addr[3]) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every read strobe and every fetch_done must match a queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_rd_en) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch actual=%h expected=none", imem_addr);
        end else begin
          chk("fetch_addr", imem_addr, addr_q.pop_front());
        end
      end
      if (fetch_done) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual_instr=%h expected=none", instr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("instr", instr, mon_e.instr);
          chk("pc_plus4", pc_plus4, mon_e.pp4);
          chk("pc_after_capt", pc, mon_e.pc);
          chk("done_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    pc_load = 1'b1; pc_in = tgt;
    @(posedge clk); #1;
    pc_load = 1'b0;
  endtask

  // One fetch with optional redirects during REQ and WAIT (timing assumes IMEM_LATENCY=1).
  task automatic do_fetch(input logic [31:0] e_addr, input logic [31:0] e_instr,
                          input logic [31:0] e_pp4, input logic [31:0] e_pc,
                          input bit req_ld, input logic [31:0] req_val,
                          input bit wait_ld, input logic [31:0] wait_val);
    addr_q.push_back(e_addr);
    exp_q.push_back('{e_instr, e_pp4, e_pc, cyc + 3});
    fetch_en = 1'b1;
    @(posedge clk); #1;
    fetch_en = 1'b0; pc_load = req_ld; pc_in = req_val;
    @(posedge clk); #1;
    pc_load = wait_ld; pc_in = wait_val;
    @(posedge clk); #1;
    pc_load = 1'b0;
    wait_idle();
  endtask

  initial begin
    int  lat;
    logic seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_ctrl", {28'b0, imem_rd_en, fetch_done, busy, pc_misalign}, 32'h0);
    rst = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;

    do_fetch(32'h0, 32'h2002_0005, 32'h4, 32'h4, 0, 0, 0, 0);
    do_fetch(32'h4, 32'h8C00_0004, 32'h8, 32'h8, 0, 0, 0, 0);

    redirect(32'h40);
    chk("redirect_idle", pc, 32'h40);
    do_fetch(32'h40, 32'h8C00_0040, 32'h44, 32'h44, 0, 0, 0, 0);

    redirect(32'h8);
    chk("redirect_back", pc, 32'h8);
    do_fetch(32'h8, 32'h8C00_0008, 32'hC, 32'h100, 0, 0, 1, 32'h100);
    do_fetch(32'h100, 32'h8C00_0100, 32'h104, 32'h300, 1, 32'h200, 1, 32'h300);
    do_fetch(32'h300, 32'h8C00_0300, 32'h304, 32'h180, 1, 32'h180, 0, 0);
    do_fetch(32'h180, 32'h8C00_0180, 32'h184, 32'h184, 0, 0, 0, 0);

    // Same-cycle start and redirect: single fetch at the new PC, one cycle later.
    addr_q.push_back(32'h20);
    exp_q.push_back('{32'h8C00_0020, 32'h24, 32'h24, cyc + 4});
    fetch_en = 1'b1; pc_load = 1'b1; pc_in = 32'h20;
    @(posedge clk); #1;
    fetch_en = 1'b0; pc_load = 1'b0;
    chk("same_cycle_pc", pc, 32'h20);
    repeat (3) begin @(posedge clk); #1; end
    wait_idle();

    redirect(32'hFFFF_FFFC);
    chk("wrap_pc_load", pc, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h73FF_FFFC, 32'h0, 32'h0, 0, 0, 0, 0);

    redirect(32'h13);
    chk("misalign_pc", pc, 32'h10);
    chk("misalign_set", {31'b0, pc_misalign}, 32'h1);
    do_fetch(32'h10, 32'h8C00_0010, 32'h14, 32'h14, 0, 0, 0, 0);
    chk("misalign_sticky", {31'b0, pc_misalign}, 32'h1);

    // fetch_en held through REQ/WAIT must not queue a second fetch.
    addr_q.push_back(32'h14);
    exp_q.push_back('{32'h8C00_0014, 32'h18, 32'h18, cyc + 3});
    fetch_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    fetch_en = 1'b0;
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_misalign", {31'b0, pc_misalign}, 32'h0);
    chk("rst2_pc", pc, 32'h0);

    // Latency-4 instance: full fetch, then abort in WAIT.
    fetch_en4 = 1'b1;
    @(posedge clk); #1;
    fetch_en4 = 1'b0;
    lat = 1;
    while (!fetch_done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat4_latency", lat, 32'd6);
    chk("lat4_instr", instr4, 32'h2002_0005);
    chk("lat4_pc", pc4, 32'h4);
    @(posedge clk); #1;

    fetch_en4 = 1'b1;
    @(posedge clk); #1;
    fetch_en4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lat4_busy_wait", {31'b0, busy4}, 32'h1);
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    chk("abort_busy", {31'b0, busy4}, 32'h0);
    chk("abort_pc", pc4, 32'h0);
    chk("abort_instr", instr4, 32'h0);
    seen = 1'b0;
    repeat (8) begin
      seen = seen | fetch_done4;
      @(posedge clk); #1;
    end
    chk("abort_no_done", {31'b0, seen}, 32'h0);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("addr_q_drained", addr_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
